// File: rtl/cos_sim_feeder_pkg.sv
// Shared definitions for the cosine-similarity engine load feeder.
package cos_sim_feeder_pkg;

  localparam int D_LEN_DEF   = 32;
  localparam int ELE_NUM_DEF = 128;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_V1   = 3'd1,
    ST_LOAD_V2   = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESULT    = 3'd4
  } state_t;

  localparam logic [1:0] SEL_IDLE = 2'd0;
  localparam logic [1:0] SEL_V1   = 2'd1;
  localparam logic [1:0] SEL_V2   = 2'd2;

endpackage

// File: rtl/cos_sim_feeder.sv
// Host-side feeder for the cosine-similarity engine: streams vct1/vct2
// words into the engine, waits for done (with a watchdog), and holds the
// result for the host.
//
// Handshakes: a host word moves on a rising edge where s_valid & s_ready;
// in the load states s_ready mirrors cs_load_ready, so that one edge is the
// host beat and the engine beat at once. s_valid may not be withdrawn by
// the feeder; the host may drop it at any time. The result moves on a
// rising edge where r_valid & r_ready; r_data is stable while r_valid is
// high and r_ready is low.
module cos_sim_feeder
  import cos_sim_feeder_pkg::*;
#(
  parameter int D_Len   = D_LEN_DEF,
  parameter int Ele_Num = ELE_NUM_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             reuse_v1,
  input  logic             clear,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [D_Len-1:0] s_data,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [D_Len-1:0] r_data,
  output logic             err,
  output logic             busy,
  output logic             v1_loaded,
  output logic             cs_we,
  output logic [1:0]       cs_vct_sel,
  output logic [D_Len-1:0] cs_data,
  input  logic             cs_load_ready,
  input  logic             cs_done,
  input  logic [D_Len-1:0] cs_result,
  output state_t           dbg_state
);

  localparam int IW = $clog2(Ele_Num) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(Ele_Num - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [TW-1:0] to_cnt;
  logic          beat;

  assign busy      = (state != ST_IDLE);
  assign r_valid   = (state == ST_RESULT);
  assign dbg_state = state;
  assign beat      = s_valid & cs_load_ready &
                     ((state == ST_LOAD_V1) || (state == ST_LOAD_V2));

  // Engine/host load-port steering: pass-through only while loading.
  always_comb begin
    s_ready    = 1'b0;
    cs_we      = 1'b0;
    cs_data    = '0;
    cs_vct_sel = SEL_IDLE;
    case (state)
      ST_LOAD_V1: begin
        cs_vct_sel = SEL_V1;
        cs_we      = s_valid;
        cs_data    = s_data;
        s_ready    = cs_load_ready;
      end
      ST_LOAD_V2: begin
        cs_vct_sel = SEL_V2;
        cs_we      = s_valid;
        cs_data    = s_data;
        s_ready    = cs_load_ready;
      end
      ST_WAIT_DONE: cs_vct_sel = SEL_V2;
      default: ;
    endcase
  end

  // Control FSM with element counter, done watchdog and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      v1_loaded <= 1'b0;
      r_data    <= '0;
    end else if (clear) begin
      // Any partially loaded vector is abandoned; engine contents are
      // treated as untrusted so the next run reloads vct1.
      state     <= ST_IDLE;
      idx       <= '0;
      to_cnt    <= '0;
      err       <= 1'b0;
      v1_loaded <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err <= 1'b0;
            idx <= '0;
            if (reuse_v1 && v1_loaded) begin
              state <= ST_LOAD_V2;
            end else begin
              v1_loaded <= 1'b0;
              state     <= ST_LOAD_V1;
            end
          end
        end
        ST_LOAD_V1: begin
          if (beat) begin
            if (idx == IDX_LAST) begin
              idx       <= '0;
              v1_loaded <= 1'b1;
              state     <= ST_LOAD_V2;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_LOAD_V2: begin
          if (beat) begin
            if (idx == IDX_LAST) begin
              idx    <= '0;
              to_cnt <= '0;
              state  <= ST_WAIT_DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (cs_done) begin
            r_data <= cs_result;
            state  <= ST_RESULT;
          end else if (to_cnt == TO_LAST) begin
            // TIMEOUT cycles elapsed without done: engine state is suspect.
            err       <= 1'b1;
            v1_loaded <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_RESULT: begin
          if (r_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
